// File: rtl/mul_issue_if.sv
// mul_issue_if -- operation/result handshake bundle for mul_issue.
//
// Carries the upstream operation offer and the downstream result handshake.
//   master : the environment side (offers operations, consumes results)
//   slave  : the mul_issue side (accepts operations, produces results)
//
// Signals
//   in_valid  upstream offers an operation
//   in_ready  block accepts the operation this cycle
//   in_op     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a/in_b 32-bit operands (in_a is the signed side of MULHSU)
//   in_tag    opaque tag returned with the result
//   out_valid result available
//   out_ready consumer takes the result this cycle
//   out_data  32-bit result
//   out_tag   tag of the operation that produced out_data
interface mul_issue_if #(
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/mul_issue.sv
// mul_issue -- two-stage issue/writeback wrapper around an external
// 32x32 signed multiplier.
//
// S1 registers the operation and drives the multiplier operands straight
// from its flops. The multiplier returns a 64-bit signed product
// combinationally; the result for the requested op is selected (with the
// unsigned high-word correction for MULHSU/MULHU) and captured into S2,
// which presents it on the result handshake.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   bus       operation/result handshake (mul_issue_if.slave)
//   flush     discards every in-flight operation; blocks acceptance
//   mul_src1  operand a to the external multiplier (S1.a)
//   mul_src2  operand b to the external multiplier (S1.b)
//   mul_res   signed 64-bit product of mul_src1 * mul_src2
module mul_issue #(
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  mul_issue_if.slave  bus,
  input  logic        flush,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [63:0] mul_res
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // Stage 1: operation waiting on the multiplier
  logic             s1_valid;
  op_e              s1_op;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: result waiting on the consumer
  logic             s2_valid;
  logic [31:0]      s2_data;
  logic [TAG_W-1:0] s2_tag;

  // Handshake control
  logic s2_free;
  logic s1_adv;
  logic accept;
  logic retire;

  // Result selection
  logic [31:0] hi_signed;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] result;

  // S2 can take a new result if it is empty or is being drained this edge.
  assign s2_free = !s2_valid || bus.out_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign retire  = s2_valid && bus.out_ready;

  // Acceptance depends only on pipeline state and flush, never on in_valid,
  // so there is no combinational path from in_valid to in_ready.
  assign bus.in_ready = !flush && (!s1_valid || s2_free);
  assign accept       = bus.in_valid && bus.in_ready;

  assign mul_src1      = s1_a;
  assign mul_src2      = s1_b;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_tag   = s2_tag;

  // The multiplier treats both operands as signed. Reinterpreting an
  // operand with its top bit set as unsigned adds 2^32 * other operand to
  // the true product, i.e. the other operand to the high word.
  assign hi_signed = mul_res[63:32];
  assign corr_a    = s1_a[31] ? s1_b : 32'h0;
  assign corr_b    = s1_b[31] ? s1_a : 32'h0;

  // NOTE: every variable written in always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    result = mul_res[31:0];
    unique case (s1_op)
      OP_MUL:    result = mul_res[31:0];
      OP_MULH:   result = hi_signed;
      OP_MULHSU: result = hi_signed + corr_b;
      OP_MULHU:  result = hi_signed + corr_a + corr_b;
      default:   result = mul_res[31:0];
    endcase
  end

  // Control state plus the registers that are visible on output ports.
  // Operands and result are cleared so the multiplier inputs and out_data
  // read as zero from reset until the first operation is loaded.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a     <= 32'h0;
      s1_b     <= 32'h0;
      s2_data  <= 32'h0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= bus.in_a;
        s1_b     <= bus.in_b;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= result;
      end else if (retire) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Op and tags are only meaningful while the matching valid bit is set,
  // so they carry no reset. Loading them during rst or flush is harmless
  // because the valid bits are cleared at the same edge.
  // NOTE: payload-only registers are left unreset; their valid bit guards them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op  <= op_e'(bus.in_op);
      s1_tag <= bus.in_tag;
    end
    if (s1_adv) begin
      s2_tag <= s1_tag;
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue -- self-checking bench for mul_issue.
//
// Models the external signed multiplier, drives operations through the
// handshake interface and scores results with a queue of expected
// {data, tag} pairs pushed on acceptance and popped on retirement.
module tb_mul_issue;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [63:0] mul_res;

  mul_issue_if #(.TAG_W(TAG_W)) bus ();

  mul_issue #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .mul_src1 (mul_src1),
    .mul_src2 (mul_src2),
    .mul_res  (mul_res)
  );

  always #5 clk = ~clk;

  // External 32x32 signed multiplier
  assign mul_res = {{32{mul_src1[31]}}, mul_src1} * {{32{mul_src2[31]}}, mul_src2};

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_pop;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out;
  int   first_out;
  int   last_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit products with the operands extended as the op
  // defines them; arithmetic is mod 2^64 so signed cases come out right.
  function automatic logic [31:0] exp_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b01:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'b10:   p = {{32{a[31]}}, a} * {32'h0, b};
      default: p = {32'h0, a} * {32'h0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling half a cycle away from the active edge
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 64'(bus.out_tag), 64'hdead);
        end else begin
          sb_pop = sb_q.pop_front();
          check("sb_data", 64'(bus.out_data), 64'(sb_pop.data));
          check("sb_tag", 64'(bus.out_tag), 64'(sb_pop.tag));
        end
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back({exp_result(bus.in_op, bus.in_a, bus.in_b), bus.in_tag});
    end
  end

  // Offer one op, returning #1 after the edge at which it was accepted.
  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 2'b00;
    bus.in_a = 32'h0;
    bus.in_b = 32'h0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    n_out = 0;
    first_out = 0;
    last_out = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_mul_src1", 64'(mul_src1), 64'd0);
    check("rst_mul_src2", 64'(mul_src2), 64'd0);
    @(posedge clk);
    #1;

    // MUL 3 * 0xFFFFFFFE, two-edge latency
    bus.out_ready = 1'b1;
    send(2'b00, 32'd3, 32'hFFFF_FFFE, 4'h1);
    bus.in_valid = 1'b0;
    check("lat_edge_k", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge_k1_valid", 64'(bus.out_valid), 64'd1);
    check("lat_edge_k1_data", 64'(bus.out_data), 64'hFFFF_FFFA);
    check("lat_edge_k1_tag", 64'(bus.out_tag), 64'h1);
    idle_cycles(2);
    check("lat_drained", 64'(bus.out_valid), 64'd0);

    // High-word variants with both operands all ones
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2);
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4);
    idle_cycles(4);

    // Eight ops back to back with out_ready held high
    n_out = 0;
    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(0, 3)), $urandom, $urandom, TAG_W'(i));
    idle_cycles(4);
    check("b2b_count", 64'(n_out), 64'd8);
    check("b2b_consecutive", 64'(last_out - first_out), 64'd7);

    // Backpressure with a full pipeline
    bus.out_ready = 1'b0;
    send(2'b11, 32'h8000_0001, 32'h1234_5678, 4'hA);
    send(2'b10, 32'h9ABC_DEF0, 32'hF000_000F, 4'hB);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_a     = 32'h7FFF_FFFF;
    bus.in_b     = 32'h8000_0000;
    bus.in_tag   = 4'hC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data", 64'(bus.out_data),
            64'(exp_result(2'b11, 32'h8000_0001, 32'h1234_5678)));
      check("bp_out_tag", 64'(bus.out_tag), 64'hA);
      check("bp_s1_hold", 64'(mul_src1), 64'h9ABC_DEF0);
      @(posedge clk);
      #1;
    end
    n_out = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    idle_cycles(4);
    check("bp_release_count", 64'(n_out), 64'd3);

    // Flush with both stages valid and the consumer stalled
    bus.out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd13, 4'h1);
    send(2'b00, 32'd17, 32'd19, 4'h2);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'hF;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    check("flush_pre_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    n_out = 0;
    bus.out_ready = 1'b1;
    send(2'b01, 32'hFFFF_FFF0, 32'd100, 4'h5);
    idle_cycles(4);
    check("flush_only_one_result", 64'(n_out), 64'd1);

    // Reset pulse mid-stream
    send(2'b00, 32'd5, 32'd7, 4'h3);
    send(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'h4);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'h6;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    n_out = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_stale", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'h7);
    idle_cycles(4);
    check("rst_mid_recovery", 64'(n_out), 64'd1);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
